// File: rtl/sap1_acc_breg.sv
// SAP-1 accumulator A and B register feeding the adder-subtractor operands.
// Optional zero/negative flags on accumulator loads: define SAP1_ACC_FLAGS_EN.
module sap1_acc_breg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] w_in,
  input  logic             la_n,
  input  logic             lb_n,
  input  logic             ea,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] w_a,
  output logic             w_a_en,
  output logic             flag_z,
  output logic             flag_n
);

  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] b_r;

  // Operand registers: W bus captured bit-for-bit; clear wins over any load.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      acc_r <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
    end else begin
      if (!la_n) begin
        acc_r <= w_in;
      end else begin
        acc_r <= acc_r;
      end
      if (!lb_n) begin
        b_r <= w_in;
      end else begin
        b_r <= b_r;
      end
    end
  end

  assign a_out = acc_r;
  assign b_out = b_r;

  // Bus drive is combinational so the accumulator reaches W in the same cycle EA rises.
  always_comb begin
    w_a    = {WIDTH{1'b0}};
    w_a_en = ea;
    if (ea) begin
      w_a = acc_r;
    end else begin
      w_a = {WIDTH{1'b0}};
    end
  end

`ifdef SAP1_ACC_FLAGS_EN
  logic flag_z_r;
  logic flag_n_r;

  // Flags track only what enters the accumulator; B loads leave them alone.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      flag_z_r <= 1'b0;
      flag_n_r <= 1'b0;
    end else if (!la_n) begin
      flag_z_r <= (w_in == {WIDTH{1'b0}});
      flag_n_r <= w_in[WIDTH-1];
    end else begin
      flag_z_r <= flag_z_r;
      flag_n_r <= flag_n_r;
    end
  end

  assign flag_z = flag_z_r;
  assign flag_n = flag_n_r;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif

endmodule
